// File: rtl/uart_pkg.sv
// uart_pkg: shared state types, frame-length helper and line levels for uart_param.
package uart_pkg;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    function automatic int frame_bits(input int data_width, input int stop_bits, input bit parity);
        return 1 + data_width + int'(parity) + stop_bits;
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period counter held at zero by clr, with wrap and mid-bit ticks.
module uart_bit_timer #(
    parameter int CLOCKS_PER_PULSE = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    output logic bit_tick,
    output logic mid_tick
);
    localparam int CW = $clog2(CLOCKS_PER_PULSE);
    logic [CW-1:0] count;
    assign bit_tick = count == CW'(CLOCKS_PER_PULSE - 1);
    assign mid_tick = count == CW'(CLOCKS_PER_PULSE / 2 - 1);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) count <= '0;
        else count <= (clr || bit_tick) ? '0 : count + 1'b1;
endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART with framing/overrun/glitch detection.
// Define UART_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
module uart_param
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int STOP_BITS        = 1,
    parameter bit PARITY_ODD       = 1'b0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_en,
    output logic                  tx,
    output logic                  tx_busy,
    input  logic                  rx,
    input  logic                  ready_clr,
    output logic                  ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);
`ifdef UART_PARITY_EN
    localparam bit HAS_PARITY = 1'b1;
`else
    localparam bit HAS_PARITY = 1'b0;
`endif
    localparam int FRAME_BITS = frame_bits(DATA_WIDTH, STOP_BITS, HAS_PARITY);
    localparam int BW = $clog2(FRAME_BITS);

    tx_state_t tx_state, tx_next;
    logic [DATA_WIDTH-1:0] tx_shift;
    logic [BW-1:0] tx_bit;
    logic tx_par, tx_tick, tx_mid_unused;

    uart_bit_timer #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)) u_tx_timer (
        .clk(clk), .rstn(rstn), .clr(tx_state == TX_IDLE),
        .bit_tick(tx_tick), .mid_tick(tx_mid_unused)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) tx_state <= TX_IDLE;
        else tx_state <= tx_next;

    // tx_bit indexes the whole frame: 0 = start, 1..DATA_WIDTH = data, then parity/stop
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   tx_next = data_en ? TX_START : TX_IDLE;
            TX_START:  if (tx_tick) tx_next = TX_DATA;
            TX_DATA:   if (tx_tick && tx_bit == BW'(DATA_WIDTH)) tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP;
            TX_STOP:   if (tx_tick && tx_bit == BW'(FRAME_BITS - 1)) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_par   <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            tx_bit <= '0;
            if (data_en) begin
                tx_shift <= data_in;
                tx_par   <= ^data_in ^ PARITY_ODD;
            end
        end else if (tx_tick) begin
            tx_bit <= tx_bit + 1'b1;
            if (tx_state == TX_DATA) tx_shift <= tx_shift >> 1;
        end

    // Decoded from registered state so reset forces the line idle asynchronously
    assign tx = (tx_state == TX_START)  ? START_LEVEL :
                (tx_state == TX_DATA)   ? tx_shift[0] :
                (tx_state == TX_PARITY) ? tx_par : IDLE_LEVEL;
    assign tx_busy = tx_state != TX_IDLE;

    rx_state_t rx_state, rx_next;
    logic rx_s1, rx_s2, rx_s3;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BW-1:0] rx_bit;
    logic rx_tick, rx_mid, done, par_bad;

    uart_bit_timer #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)) u_rx_timer (
        .clk(clk), .rstn(rstn), .clr(rx_state == RX_IDLE),
        .bit_tick(rx_tick), .mid_tick(rx_mid)
    );

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) {rx_s1, rx_s2, rx_s3} <= {3{IDLE_LEVEL}};
        else {rx_s1, rx_s2, rx_s3} <= {rx, rx_s1, rx_s2};

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rx_state <= RX_IDLE;
        else rx_state <= rx_next;

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_s3 == IDLE_LEVEL && rx_s2 == START_LEVEL) rx_next = RX_START;
            RX_START:  if (rx_mid && rx_s2 != START_LEVEL) rx_next = RX_IDLE;
                       else if (rx_tick) rx_next = RX_DATA;
            RX_DATA:   if (rx_tick && rx_bit == BW'(DATA_WIDTH)) rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            RX_STOP:   if (rx_mid) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_bit <= (rx_state == RX_IDLE) ? '0 : rx_tick ? rx_bit + 1'b1 : rx_bit;
            if (rx_state == RX_DATA && rx_mid) rx_shift <= {rx_s2, rx_shift[DATA_WIDTH-1:1]};
        end

`ifdef UART_PARITY_EN
    logic rx_par;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) rx_par <= 1'b0;
        else if (rx_state == RX_PARITY && rx_mid) rx_par <= rx_s2;
    assign par_bad = rx_par != (^rx_shift ^ PARITY_ODD);
`else
    assign par_bad = 1'b0;
`endif

    assign done = rx_state == RX_STOP && rx_mid;

    // A completing frame beats a simultaneous ready_clr
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            ready      <= 1'b0;
            data_out   <= '0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (done && (!ready || ready_clr)) begin
            ready      <= 1'b1;
            data_out   <= rx_shift;
            frame_err  <= rx_s2 != IDLE_LEVEL;
            parity_err <= par_bad;
            overrun    <= 1'b0;
        end else if (done) begin
            overrun <= 1'b1;
        end else if (ready_clr) begin
            ready      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end
endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed, table-driven self-checking bench for uart_param.
module tb_uart_param;
    localparam int CPP = 16;
    localparam int DW  = 8;
    localparam int SB  = 1;
`ifdef UART_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int N   = (1 + DW + P + SB) * CPP;
    localparam int LAT = 3 + (1 + DW + P) * CPP + CPP / 2;

    logic clk = 1'b0, rstn = 1'b0;
    logic [DW-1:0] data_in = '0, data_out;
    logic data_en = 1'b0, ready_clr = 1'b0;
    logic tx, tx_busy, rx, ready, frame_err, parity_err, overrun;
    logic loop = 1'b0, rx_drv = 1'b1;
    assign rx = loop ? tx : rx_drv;

    uart_param #(.CLOCKS_PER_PULSE(CPP), .DATA_WIDTH(DW), .STOP_BITS(SB), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rstn(rstn), .data_in(data_in), .data_en(data_en), .tx(tx), .tx_busy(tx_busy),
        .rx(rx), .ready_clr(ready_clr), .ready(ready), .data_out(data_out),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive_bit(input logic b);
        rx_drv = b;
        repeat (CPP) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic flip);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        if (P == 1) drive_bit(^d ^ flip);
        drive_bit(stop);
        for (int i = 1; i < SB; i++) drive_bit(1'b1);
        rx_drv = 1'b1;
    endtask

    task automatic measure(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!ready && n < 2 * N);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!ready && n < 2 * N) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, ready, 1);
    endtask

    task automatic clear_ready();
        @(negedge clk); ready_clr = 1'b1;
        @(negedge clk); ready_clr = 1'b0;
    endtask

    task automatic tx_check(input logic [DW-1:0] d, input string tag);
        int busy_cnt, b;
        logic e;
        @(negedge clk); data_in = d; data_en = 1'b1;
        @(posedge clk); #1;
        data_en = 1'b0; data_in = ~d;
        busy_cnt = 0;
        for (int c = 0; c < N; c++) begin
            if (tx_busy) busy_cnt++;
            if (c % CPP == CPP / 2) begin
                b = c / CPP;
                e = (b == 0) ? 1'b0 : (b <= DW) ? d[b-1] : (P == 1 && b == DW + 1) ? ^d : 1'b1;
                check($sformatf("%s_bit%0d", tag, b), tx, e);
            end
            if (c == 40) data_en = 1'b1;
            if (c == 42) data_en = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, "_busy_len"}, busy_cnt, N);
        check({tag, "_busy_end"}, tx_busy, 0);
        check({tag, "_tx_idle"}, tx, 1);
    endtask

    typedef struct {
        logic [DW-1:0] d;
        logic          stop;
        logic          flip;
        logic          ferr;
        logic          perr;
    } vec_t;
    vec_t vecs[5];

    initial begin
        int n, bsy;
        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'(P)};
        vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_ready", ready, 0);
        check("rst_data", data_out, 0);
        check("rst_flags", {frame_err, parity_err, overrun}, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        tx_check(8'hA5, "txA5");

        foreach (vecs[i]) begin
            @(negedge clk);
            fork
                send_frame(vecs[i].d, vecs[i].stop, vecs[i].flip);
                measure(n);
            join
            check($sformatf("v%0d_latency", i), n, LAT);
            check($sformatf("v%0d_data", i), data_out, vecs[i].d);
            check($sformatf("v%0d_ferr", i), frame_err, vecs[i].ferr);
            check($sformatf("v%0d_perr", i), parity_err, vecs[i].perr);
            check($sformatf("v%0d_ovr", i), overrun, 0);
            clear_ready();
            check($sformatf("v%0d_clr", i), {ready, frame_err, parity_err, overrun}, 0);
        end

        loop = 1'b1;
        @(negedge clk); data_in = 8'h3C; data_en = 1'b1;
        @(negedge clk); data_en = 1'b0;
        bsy = 0;
        while (tx_busy && bsy < 2 * N) begin @(negedge clk); bsy++; end
        check("lb_busy_drop", tx_busy, 0);
        data_in = 8'hFF; data_en = 1'b1;
        @(negedge clk); data_en = 1'b0;
        wait_ready("lb1");
        check("lb1_data", data_out, 8'h3C);
        check("lb1_flags", {frame_err, parity_err, overrun}, 0);
        clear_ready();
        check("lb_clr", ready, 0);
        wait_ready("lb2");
        check("lb2_data", data_out, 8'hFF);
        check("lb2_flags", {frame_err, parity_err, overrun}, 0);
        bsy = 0;
        while (tx_busy && bsy < 2 * N) begin @(negedge clk); bsy++; end
        loop = 1'b0;
        clear_ready();

        send_frame(8'h11, 1'b1, 1'b0);
        wait_ready("ovr1");
        check("ovr1_data", data_out, 8'h11);
        send_frame(8'h22, 1'b1, 1'b0);
        check("ovr_flag", overrun, 1);
        check("ovr_hold", data_out, 8'h11);
        check("ovr_ready", ready, 1);
        check("ovr_ferr", frame_err, 0);

        fork
            send_frame(8'h33, 1'b1, 1'b0);
            begin
                repeat (LAT - 1) @(posedge clk);
                @(negedge clk); ready_clr = 1'b1;
                @(negedge clk); ready_clr = 1'b0;
            end
        join
        check("race_ready", ready, 1);
        check("race_data", data_out, 8'h33);
        check("race_ovr", overrun, 0);
        clear_ready();

        @(negedge clk); rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (N) @(negedge clk);
        check("glitch_ready", ready, 0);
        check("glitch_data", data_out, 8'h33);
        check("glitch_flags", {frame_err, parity_err, overrun}, 0);

        @(negedge clk); data_in = 8'hC3; data_en = 1'b1;
        @(posedge clk); #1; data_en = 1'b0;
        repeat (3 * CPP + CPP / 2) @(posedge clk);
        #2;
        check("pre_rst_tx", tx, 0);
        check("pre_rst_busy", tx_busy, 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", tx_busy, 0);
        @(negedge clk); rstn = 1'b1;
        tx_check(8'h5A, "post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
